// File: rtl/seq_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// seq_ctrl_pkg -- state encoding and datapath widths shared by seq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------
package seq_ctrl_pkg;
  localparam int STEP_W = 8;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage
`default_nettype wire

// File: rtl/seq_tick.sv
`default_nettype none
// ---------------------------------------------------------------------
// seq_tick -- NP-bit free-running divider, tick on all-ones while enabled
// Rev 1.0
// ---------------------------------------------------------------------
module seq_tick #(
  parameter int NP = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  logic [NP-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + NP'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = en && (&cnt_q);
endmodule
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// seq_ctrl -- two-register swap sequencer; SEQ_CTRL_LOAD_EN adds load path
// Rev 1.0
// ---------------------------------------------------------------------
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int                NP   = 23,
  parameter logic [DATA_W-1:0] INI0 = 4'b1010,
  parameter logic [DATA_W-1:0] INI1 = 4'b0101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] nsteps,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data0,
  input  logic [DATA_W-1:0] load_data1,
  output logic              load_ready,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] reg0_q, reg0_d, reg1_q, reg1_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d, nsteps_q, nsteps_d;
  logic              tick;
  logic              load_accept;

  // Divider is held at zero outside RUN, so every run starts a full period.
  seq_tick #(.NP(NP)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_RUN),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

`ifdef SEQ_CTRL_LOAD_EN
  assign load_ready  = (state_q == ST_IDLE) && !start;
  assign load_accept = load_valid && load_ready;
`else
  logic unused_load;
  assign load_ready  = 1'b0;
  assign load_accept = 1'b0;
  assign unused_load = &{1'b0, load_valid, load_data0, load_data1};
`endif

  always_comb begin
    state_d    = state_q;
    reg0_d     = reg0_q;
    reg1_d     = reg1_q;
    step_cnt_d = step_cnt_q;
    nsteps_d   = nsteps_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_RUN;
          nsteps_d   = nsteps;
          step_cnt_d = '0;
        end else if (load_accept) begin
          state_d = ST_LOAD;
          reg0_d  = load_data0;
          reg1_d  = load_data1;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          reg0_d     = reg1_q;
          reg1_d     = reg0_q;
          step_cnt_d = step_cnt_q + 8'd1;
          // nsteps of zero means free-running, so the wrap to zero never ends it
          if ((nsteps_q != '0) && (step_cnt_q + 8'd1 == nsteps_q))
            state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      reg0_q     <= INI0;
      reg1_q     <= INI1;
      step_cnt_q <= '0;
      nsteps_q   <= '0;
    end else begin
      state_q    <= state_d;
      reg0_q     <= reg0_d;
      reg1_q     <= reg1_d;
      step_cnt_q <= step_cnt_d;
      nsteps_q   <= nsteps_d;
    end
  end

  assign data     = reg0_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign step_cnt = step_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_seq_ctrl -- self-checking bench for seq_ctrl (NP=2), honours SEQ_CTRL_LOAD_EN
// Rev 1.0
// ---------------------------------------------------------------------
module tb_seq_ctrl;
`ifdef SEQ_CTRL_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif
  localparam int PERIOD = 4;  // 2^NP with NP=2
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, start, stop, load_valid;
  logic [7:0] nsteps;
  logic [3:0] load_data0, load_data1;
  logic       load_ready, busy, done;
  logic [3:0] data;
  logic [7:0] step_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: swap pair, count of cycles spent in the current run
  int         m_mode = M_IDLE;
  int         m_age  = 0;
  logic [3:0] m_reg0 = 4'b1010, m_reg1 = 4'b0101;
  logic [7:0] m_cnt  = 8'd0, m_n = 8'd0;
  bit         m_valid = 1'b0;

  seq_ctrl #(.NP(2), .INI0(4'b1010), .INI1(4'b0101)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .nsteps     (nsteps),
    .load_valid (load_valid),
    .load_data0 (load_data0),
    .load_data1 (load_data1),
    .load_ready (load_ready),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic sp, input logic [7:0] n,
                            input logic lv, input logic [3:0] d0, input logic [3:0] d1);
    logic [3:0] t;
    if (!r) begin
      m_mode = M_IDLE; m_age = 0; m_reg0 = 4'b1010; m_reg1 = 4'b0101;
      m_cnt = 8'd0; m_n = 8'd0; m_valid = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (s && !sp) begin
            m_mode = M_RUN; m_age = 0; m_cnt = 8'd0; m_n = n;
          end else if (LOAD_EN && lv && !s) begin
            m_mode = M_LOAD; m_reg0 = d0; m_reg1 = d1;
          end
        end
        M_LOAD: m_mode = M_IDLE;
        M_RUN: begin
          if (sp) m_mode = M_IDLE;
          else begin
            m_age++;
            if (m_age % PERIOD == 0) begin
              t = m_reg0; m_reg0 = m_reg1; m_reg1 = t;
              m_cnt = m_cnt + 8'd1;
              if (m_n != 8'd0 && m_cnt == m_n) m_mode = M_DONE;
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Called at a negedge: apply inputs, compare, take one posedge, return at next negedge.
  task automatic step(input logic r, input logic s, input logic sp, input logic [7:0] n,
                      input logic lv, input logic [3:0] d0, input logic [3:0] d1);
    rst = r; start = s; stop = sp; nsteps = n;
    load_valid = lv; load_data0 = d0; load_data1 = d1;
    #1;
    if (m_valid) begin
      check("data", 8'(data), 8'(m_reg0));
      check("busy", 8'(busy), 8'(m_mode == M_RUN));
      check("done", 8'(done), 8'(m_mode == M_DONE));
      check("step_cnt", step_cnt, m_cnt);
      check("load_ready", 8'(load_ready), 8'(LOAD_EN && m_mode == M_IDLE && !s));
    end
    @(posedge clk);
    model_edge(r, s, sp, n, lv, d0, d1);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    #1;
    check("rst_data", 8'(data), 8'h0a);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_done", 8'(done), 8'h0);
    check("rst_step_cnt", step_cnt, 8'h0);
    check("rst_load_ready", 8'(load_ready), 8'(LOAD_EN));

    // Finite run of three steps
    step(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 4'h0, 4'h0);
    idle(3);
    check("run3_pre_swap", 8'(data), 8'h0a);
    idle(1);
    check("run3_swap1", 8'(data), 8'h05);
    idle(4);
    check("run3_swap2", 8'(data), 8'h0a);
    idle(4);
    check("run3_done", 8'(done), 8'h1);
    check("run3_busy", 8'(busy), 8'h0);
    check("run3_data", 8'(data), 8'h05);
    check("run3_cnt", step_cnt, 8'd3);
    idle(1);
    check("run3_done_pulse", 8'(done), 8'h0);
    check("run3_cnt_hold", step_cnt, 8'd3);

    // Free run stopped after ten RUN cycles
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);
    idle(9);
    step(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'h0, 4'h0);
    check("stop10_data", 8'(data), 8'h0a);
    check("stop10_cnt", step_cnt, 8'd2);
    check("stop10_busy", 8'(busy), 8'h0);
    check("stop10_done", 8'(done), 8'h0);

    // Stop on the tick cycle suppresses the swap
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'h0, 4'h0);
    check("stop_tick_data", 8'(data), 8'h0a);
    check("stop_tick_cnt", step_cnt, 8'd0);
    check("stop_tick_busy", 8'(busy), 8'h0);

    // start together with stop stays idle
    step(1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 4'h0, 4'h0);
    check("start_stop_busy", 8'(busy), 8'h0);

    // Load path (ignored when the feature is compiled out)
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0011, 4'b1100);
    check("load_data", 8'(data), LOAD_EN ? 8'h03 : 8'h0a);
    check("load_ready_low", 8'(load_ready), 8'h0);
    idle(1);
    check("load_ready_back", 8'(load_ready), 8'(LOAD_EN));
    step(1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 4'hf, 4'hf);
    idle(4);
    check("load_run_data", 8'(data), LOAD_EN ? 8'h0c : 8'h05);

    // Reset during the second step period aborts the run
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'h0, 4'h0);
    idle(5);
    do_reset();
    check("rst_run_data", 8'(data), 8'h0a);
    check("rst_run_cnt", step_cnt, 8'd0);
    check("rst_run_busy", 8'(busy), 8'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) != 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 29) == 0),
           8'($urandom_range(0, 5)),
           1'($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter NP, default 23, tick-divider bits; one step every 2^NP clk cycles while running.
REQ-002 Parameter INI0, default 4'b1010, reset/initial value of register 0.
REQ-003 Parameter INI1, default 4'b0101, reset/initial value of register 1.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin stepping.
REQ-007 stop  in  1  one-cycle request to abort stepping.
REQ-008 nsteps  in  8  step count sampled at start; 0 = run until stop.
REQ-009 load_valid  in  1  new register pair offered.
REQ-010 load_data0, load_data1  in  4 each  values for register 0 / register 1.
REQ-011 load_ready  out  1  controller accepts a load this cycle.
REQ-012 data  out  4  current register 0 contents.
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  one-cycle pulse on finite-run completion.
REQ-015 step_cnt  out  8  swaps performed since last start.

Function
REQ-016 FSM states IDLE, LOAD, RUN, DONE shall be used; no other reachable states.
REQ-017 IDLE: start=1 and stop=0 -> RUN next cycle; nsteps latched, step_cnt cleared, tick counter cleared.
REQ-018 IDLE: start and stop asserted together -> stay IDLE, no state change.
REQ-019 IDLE: load_valid & load_ready -> LOAD; next edge reg0<=load_data0, reg1<=load_data1.
REQ-020 IDLE: start and load_valid together -> start wins, load not accepted (load_ready=0 that cycle).
REQ-021 LOAD lasts exactly one cycle, then IDLE; load_ready=0 in LOAD.
REQ-022 RUN: tick counter increments every cycle; tick asserted when counter is all ones, counter wraps to 0.
REQ-023 RUN tick: reg0 and reg1 swap on the same edge, step_cnt increments (8-bit wrap 255->0).
REQ-024 First swap occurs 2^NP cycles after entering RUN.
REQ-025 Finite run: tick with step_cnt+1 == latched nsteps -> swap, then DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE; busy=0 in DONE.
REQ-027 RUN: stop=1 -> IDLE next cycle, registers hold, no swap even if tick same cycle.
REQ-028 start during RUN/DONE/LOAD ignored; load_valid outside IDLE ignored.
REQ-029 step_cnt holds its value in IDLE until next start.

Reset
REQ-030 rst=0 at a clk edge: state IDLE, reg0=INI0, reg1=INI1, data=INI0, busy=0, done=0, step_cnt=0, tick counter 0, load_ready=1 after release.
REQ-031 Reset mid-RUN or mid-LOAD shall abort immediately; pending load discarded.

Configuration
REQ-032 Macro SEQ_CTRL_LOAD_EN defined: load handshake and LOAD state per REQ-019..021.
REQ-033 SEQ_CTRL_LOAD_EN undefined: LOAD state absent, load_ready tied 0, load_valid/load_data ignored, registers change only by reset and swap.

Structure
REQ-034 State encodings and widths (step counter 8, data 4) shall live in shared header seq_ctrl_defs.vh.
REQ-035 Tick generation shall be sub-module seq_tick (NP-bit counter, clear and enable inputs, tick output).
REQ-036 Registers reuse the team's existing register block with INI parameters; no clock derived from logic.

Verification (NP=2, tick every 4 cycles)
REQ-037 Reset release -> data=1010, busy=0, done=0, step_cnt=0, load_ready=1.
REQ-038 start, nsteps=3 -> data 0101, 1010, 0101 at RUN cycles 4, 8, 12; done pulse one cycle; step_cnt=3; busy low.
REQ-039 start, nsteps=0, stop after 10 cycles -> two swaps, data=1010, IDLE, step_cnt=2, no done pulse.
REQ-040 stop coinciding with a tick -> no swap, IDLE, step_cnt unchanged.
REQ-041 SEQ_CTRL_LOAD_EN: load 0011/1100 in IDLE -> load_ready low one cycle, data=0011; start nsteps=1 -> data=1100.
REQ-042 rst low during RUN step 2 -> next cycle data=1010, step_cnt=0, state IDLE.
